// File: rtl/fp_normalize_round.sv
// Normalize/round stage behind the binary32 adder datapath.
// Iterative left-normalize, RNE rounding, IEEE pack with status flags.
module fp_normalize_round #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  localparam int M     = FRAC_W + 5,
  localparam int W     = 1 + EXP_W + FRAC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [M-1:0]     in_mant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic             out_zero
);

  typedef enum logic [2:0] {
    IDLE, CARRY, NORM, ROUND, DONE
  } state_t;

  localparam logic [EXP_W:0] EMAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] ONE  = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [W-1:0]   QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  state_t            state_q, state_d;
  logic              sign_q, sign_d;
  logic [EXP_W:0]    exp_q, exp_d;
  logic [M-1:0]      mant_q, mant_d;
  logic [W-1:0]      res_q, res_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              zero_q, zero_d;

  logic [FRAC_W:0]   sig;
  logic              rnd_inc;
  logic [FRAC_W+1:0] rnd_sum;
  logic [EXP_W:0]    exp_inc;
  logic [EXP_W:0]    r_exp;
  logic [FRAC_W-1:0] r_frac;
  logic              r_hid;
  logic [W-1:0]      inf_res;

  assign sig     = mant_q[M-2:3];
  assign rnd_inc = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
  assign rnd_sum = {1'b0, sig} + {{(FRAC_W+1){1'b0}}, rnd_inc};
  assign exp_inc = exp_q + ONE;
  assign inf_res = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};

  // Rounding carry past the hidden bit renormalizes by one place.
  always_comb begin
    if (rnd_sum[FRAC_W+1]) begin
      r_exp  = exp_inc;
      r_frac = rnd_sum[FRAC_W:1];
      r_hid  = 1'b1;
    end else begin
      r_exp  = exp_q;
      r_frac = rnd_sum[FRAC_W-1:0];
      r_hid  = rnd_sum[FRAC_W];
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = in_sign;
          exp_d  = {1'b0, in_exp};
          mant_d = in_mant;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          zero_d = 1'b0;
          if (&in_exp) begin
            state_d = DONE;
            if (|in_mant[M-3:3]) res_d = QNAN;
            else res_d = {in_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          end else if (in_mant == '0) begin
            state_d = DONE;
            res_d   = '0;
            zero_d  = 1'b1;
          end else if (in_mant[M-1]) begin
            state_d = CARRY;
          end else if (!in_mant[M-2]) begin
            state_d = NORM;
          end else begin
            state_d = ROUND;
          end
        end
      end
      CARRY: begin
        mant_d = {1'b0, mant_q[M-1:2], |mant_q[1:0]};
        exp_d  = exp_inc;
        if (exp_inc >= EMAX) begin
          state_d = DONE;
          res_d   = inf_res;
          ovf_d   = 1'b1;
        end else begin
          state_d = ROUND;
        end
      end
      NORM: begin
        if (!mant_q[M-2] && exp_q > ONE) begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - ONE;
        end
        if (mant_d[M-2] || exp_d <= ONE) state_d = ROUND;
      end
      ROUND: begin
        state_d = DONE;
        if (r_exp >= EMAX) begin
          res_d = inf_res;
          ovf_d = 1'b1;
        end else begin
          res_d  = {sign_q, r_hid ? r_exp[EXP_W-1:0] : {EXP_W{1'b0}},
                    r_frac};
          unf_d  = !r_hid && (|r_frac);
          zero_d = !r_hid && !(|r_frac);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign out_result    = res_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;
  assign out_zero      = zero_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed bench for fp_normalize_round.
// Hand-computed binary32 results, flags and latencies.
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [27:0] in_mant = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_zero;

  int passed = 0;
  int total  = 0;

  fp_normalize_round dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_mant      (in_mant),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .out_underflow(out_underflow),
    .out_zero     (out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // flags packed as {overflow, underflow, zero}
  task automatic issue(input logic s, input logic [7:0] e,
                       input logic [27:0] m);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      step();
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic s, input logic [7:0] e,
                     input logic [27:0] m, input logic [31:0] res,
                     input logic [2:0] flg, input int lat_exp);
    int lat;
    issue(s, e, m);
    wait_valid(lat);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_lat"}, lat, lat_exp);
    chk({tag, "_res"}, out_result, res);
    chk({tag, "_flags"},
        {29'd0, out_overflow, out_underflow, out_zero}, {29'd0, flg});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drain"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_res", out_result, 32'd0);
    chk("rst_flags", {29'd0, out_overflow, out_underflow, out_zero}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    run("carry3",   1'b0, 8'h7F, 28'hC000000, 32'h40400000, 3'b000, 3);
    run("zero",     1'b1, 8'h81, 28'h0000000, 32'h00000000, 3'b001, 1);
    run("norm2",    1'b0, 8'h82, 28'h1000000, 32'h40000000, 3'b000, 4);
    run("rnd_up",   1'b0, 8'h7F, 28'h7FFFFFC, 32'h40000000, 3'b000, 2);
    run("rnd_tie",  1'b0, 8'h7F, 28'h4000004, 32'h3F800000, 3'b000, 2);
    run("c_ovf",    1'b0, 8'hFE, 28'hC000000, 32'h7F800000, 3'b100, 2);
    run("subn",     1'b0, 8'h01, 28'h2000000, 32'h00400000, 3'b010, 3);
    run("r_ovf",    1'b0, 8'hFE, 28'h7FFFFFC, 32'h7F800000, 3'b100, 2);
    run("nan",      1'b0, 8'hFF, 28'h0000008, 32'h7FC00000, 3'b000, 1);
    run("ninf",     1'b1, 8'hFF, 28'h4000000, 32'hFF800000, 3'b000, 1);
    run("sub_up",   1'b0, 8'h01, 28'h3FFFFFC, 32'h00800000, 3'b000, 3);
    run("c_sticky", 1'b0, 8'h7F, 28'hC000009, 32'h40400001, 3'b000, 3);
    run("c_tie",    1'b0, 8'h7F, 28'hC000008, 32'h40400000, 3'b000, 3);

    issue(1'b1, 8'h7F, 28'hC000000);
    wait_valid(lat);
    chk("hold_lat", lat, 3);
    held = out_result;
    chk("hold_first", held, 32'hC0400000);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_res", out_result, 32'hC0400000);
      chk("hold_vr", {30'd0, out_valid, in_ready}, 32'd2);
      chk("hold_flags",
          {29'd0, out_overflow, out_underflow, out_zero}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hold_drain", {30'd0, out_valid, in_ready}, 32'd1);

    issue(1'b0, 8'h9F, 28'h0000008);
    step();
    step();
    chk("norm_busy", {30'd0, out_valid, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_res", out_result, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("abort_ready", {30'd0, out_valid, in_ready}, 32'd1);
    for (int i = 0; i < 30; i++) step();
    chk("abort_quiet", {31'd0, out_valid}, 32'd0);

    run("post_rst", 1'b0, 8'h7F, 28'h4000004, 32'h3F800000, 3'b000, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
